// File: rtl/aes128_iter_core_if.sv
// Valid/ready bundle for the iterative AES-128 core:
// block in (plaintext + key), ciphertext out, busy flag.
interface aes128_iter_core_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] data_in;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] data_out;
    logic         busy;

    modport master (
        output in_valid, data_in, key, out_ready,
        input  in_ready, out_valid, data_out, busy
    );

    modport slave (
        input  in_valid, data_in, key, out_ready,
        output in_ready, out_valid, data_out, busy
    );
endinterface

// File: rtl/aes128_iter_core.sv
// Iterative AES-128 encryptor, UNROLL rounds per clock,
// round keys derived on the fly next to the datapath.
module aes128_iter_core #(
    parameter int UNROLL = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    aes128_iter_core_if.slave   bus
);
    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 5 && UNROLL != 10) begin : g_bad_unroll
        $error("aes128_iter_core: UNROLL must be 1, 2, 5 or 10");
    end

    localparam logic [3:0] LAST = 4'(10 / UNROLL - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e       state_q, state_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rk_q, rk_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] dout_q, dout_d;

    logic [127:0] st_nx, rk_nx;
    logic [7:0]   rc_nx;
    logic         accept;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Inverse as a^254 by square-and-multiply, then the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] v;
        p = a;
        v = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gmul(p, p);
            v = gmul(v, p);
        end
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
                 ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]),
             sbox(w3[7:0]), sbox(w3[31:24])};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s,
                                               input logic [127:0] k,
                                               input logic         last);
        logic [7:0]   b [16];
        logic [7:0]   a [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                a[4*c+r] = b[4*((c+r)%4)+r];
        for (int c = 0; c < 4; c++) begin
            if (last)
                o[127-32*c -: 32] = {a[4*c], a[4*c+1], a[4*c+2], a[4*c+3]};
            else
                o[127-32*c -: 32] = {
                    xtime(a[4*c]) ^ gmul(a[4*c+1], 8'h03) ^ a[4*c+2] ^ a[4*c+3],
                    a[4*c] ^ xtime(a[4*c+1]) ^ gmul(a[4*c+2], 8'h03) ^ a[4*c+3],
                    a[4*c] ^ a[4*c+1] ^ xtime(a[4*c+2]) ^ gmul(a[4*c+3], 8'h03),
                    gmul(a[4*c], 8'h03) ^ a[4*c+1] ^ a[4*c+2] ^ xtime(a[4*c+3])};
        end
        return o ^ k;
    endfunction

    always_comb begin
        st_nx = st_q;
        rk_nx = rk_q;
        rc_nx = rcon_q;
        for (int i = 0; i < UNROLL; i++) begin
            rk_nx = key_step(rk_nx, rc_nx);
            rc_nx = xtime(rc_nx);
            st_nx = aes_round(st_nx, rk_nx, (int'(cnt_q) * UNROLL + i) == 9);
        end
    end

    // in_ready is held low while reset is asserted
    assign bus.in_ready  = rst_n & ((state_q == IDLE) |
                                    ((state_q == DONE) & bus.out_ready));
    assign accept        = bus.in_valid & bus.in_ready;
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == BUSY);
    assign bus.data_out  = dout_q;

    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        rk_d    = rk_q;
        rcon_d  = rcon_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        unique case (state_q)
            IDLE: ;
            BUSY: begin
                st_d   = st_nx;
                rk_d   = rk_nx;
                rcon_d = rc_nx;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == LAST) begin
                    dout_d  = st_nx;
                    state_d = DONE;
                end
            end
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            st_d    = bus.data_in ^ bus.key;
            rk_d    = bus.key;
            rcon_d  = 8'h01;
            cnt_d   = 4'd0;
            state_d = BUSY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            st_q    <= '0;
            rk_q    <= '0;
            rcon_q  <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            rk_q    <= rk_d;
            rcon_q  <= rcon_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
        end
    end
endmodule

// File: tb/tb_aes128_iter_core.sv
// Bench for aes128_iter_core: FIPS vectors, random blocks,
// backpressure, back-to-back and async reset against a table model.
module tb_aes128_iter_core;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes128_iter_core_if bus();
    aes128_iter_core #(.UNROLL(1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );

    logic         xv  [3];
    logic         xov [3];
    logic [127:0] xdo [3];
    logic [127:0] xpt, xkey;

    for (genvar g = 0; g < 3; g++) begin : gu
        localparam int U = (g == 0) ? 2 : (g == 1) ? 5 : 10;
        aes128_iter_core_if gi();
        aes128_iter_core #(.UNROLL(U)) dut_u (
            .clk(clk), .rst_n(rst_n), .bus(gi.slave)
        );
        assign gi.in_valid  = xv[g];
        assign gi.data_in   = xpt;
        assign gi.key       = xkey;
        assign gi.out_ready = 1'b1;
        assign xov[g]       = gi.out_valid;
        assign xdo[g]       = gi.data_out;
    end

    localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PB  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CB  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KC  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PC  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CC  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Reference model: table S-box built by brute-force inverse search
    logic [7:0] sb [256];

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        int p, x;
        p = 0;
        x = int'(a);
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x << 1;
            if (x > 255) x = x ^ 'h11b;
        end
        return 8'(p);
    endfunction

    task automatic build_sbox();
        logic [7:0] v, o, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            v = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) v = 8'(y);
            for (int i = 0; i < 8; i++)
                o[i] = v[i] ^ v[(i+4)%8] ^ v[(i+5)%8]
                     ^ v[(i+6)%8] ^ v[(i+7)%8] ^ c[i];
            sb[x] = o;
        end
    endtask

    function automatic logic [127:0] ref_enc(input logic [127:0] pt,
                                             input logic [127:0] k);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [127:0] o;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]],
                       sb[tmp[15:8]], sb[tmp[7:0]]};
                tmp[31:24] = tmp[31:24] ^ rc;
                rc = gm(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++)
            s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
            for (int col = 0; col < 4; col++)
                for (int row = 0; row < 4; row++)
                    s[4*col+row] = t[4*((col+row)%4)+row];
            if (r < 10)
                for (int col = 0; col < 4; col++) begin
                    a0 = s[4*col];   a1 = s[4*col+1];
                    a2 = s[4*col+2]; a3 = s[4*col+3];
                    s[4*col]   = gm(a0,2) ^ gm(a1,3) ^ a2 ^ a3;
                    s[4*col+1] = a0 ^ gm(a1,2) ^ gm(a2,3) ^ a3;
                    s[4*col+2] = a0 ^ a1 ^ gm(a2,2) ^ gm(a3,3);
                    s[4*col+3] = gm(a0,3) ^ a1 ^ a2 ^ gm(a3,2);
                end
            for (int col = 0; col < 4; col++)
                for (int row = 0; row < 4; row++)
                    s[4*col+row] = s[4*col+row] ^ w[4*r+col][31-8*row -: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Drive one block, count edges to out_valid, hold off the sink `stall` cycles
    task automatic run_block(input logic [127:0] pt, input logic [127:0] k,
                             input int stall, input bit toggle,
                             output int lat, output logic [127:0] ct);
        int w;
        lat = -1;
        ct  = '0;
        @(negedge clk);
        bus.data_in   = pt;
        bus.key       = k;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        #1;
        w = 0;
        while (!bus.in_ready && w < 50) begin
            @(negedge clk); #1; w++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", 128'(bus.in_ready), 128'd1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            if (toggle) begin
                bus.data_in = rnd128();
                bus.key     = rnd128();
            end
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.out_valid) begin
            chk("done_timeout", 128'(bus.out_valid), 128'd1);
            return;
        end
        ct = bus.data_out;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk("stall_hold", bus.data_out, ct);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("valid_drop", 128'(bus.out_valid), 128'd0);
    endtask

    int           lat, w, idx, got, cyc;
    int           xlat [3];
    logic [127:0] ct, hold, exp_a;
    logic [127:0] vp [8];
    logic [127:0] vk [8];

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.data_in   = '0;
        bus.key       = '0;
        xv   = '{default: 1'b0};
        xpt  = PC;
        xkey = KC;
        build_sbox();
        chk("model_B", ref_enc(PB, KB), CB);
        chk("model_C1", ref_enc(PC, KC), CC);

        #1;
        chk("rst_in_ready", 128'(bus.in_ready), 128'd0);
        chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("rst_busy", 128'(bus.busy), 128'd0);
        chk("rst_data_out", bus.data_out, 128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_in_ready", 128'(bus.in_ready), 128'd1);

        // App.B on UNROLL=1
        run_block(PB, KB, 0, 1'b0, lat, ct);
        chk("B_latency", 128'(lat), 128'd10);
        chk("B_ct", ct, CB);

        // App.C.1 on UNROLL=2,5,10
        @(negedge clk);
        xv = '{default: 1'b1};
        @(posedge clk); #1;
        xv = '{default: 1'b0};
        xlat = '{default: 0};
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            for (int g = 0; g < 3; g++)
                if (xov[g] && xlat[g] == 0) begin
                    xlat[g] = k;
                    chk("unroll_ct", xdo[g], CC);
                end
        end
        chk("lat_u2", 128'(xlat[0]), 128'd5);
        chk("lat_u5", 128'(xlat[1]), 128'd2);
        chk("lat_u10", 128'(xlat[2]), 128'd1);

        // Backpressure with a pending second block
        run_block(PC, KC, 0, 1'b0, lat, ct);
        chk("C1_ct", ct, CC);
        @(negedge clk);
        bus.data_in  = PB;
        bus.key      = KB;
        bus.in_valid = 1'b1;
        #1;
        while (!bus.in_ready) begin
            @(negedge clk); #1;
        end
        @(posedge clk); #1;
        bus.data_in = PC;
        bus.key     = KC;
        w = 0;
        while (!bus.out_valid && w < 40) begin
            @(posedge clk); #1; w++;
        end
        chk("bp_valid", 128'(bus.out_valid), 128'd1);
        hold = bus.data_out;
        chk("bp_first", hold, CB);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("bp_data", bus.data_out, hold);
            chk("bp_in_ready", 128'(bus.in_ready), 128'd0);
            chk("bp_out_valid", 128'(bus.out_valid), 128'd1);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 128'(bus.in_ready), 128'd1);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk("bp_both_hs_busy", 128'(bus.busy), 128'd1);
        chk("bp_both_hs_valid", 128'(bus.out_valid), 128'd0);
        w = 0;
        while (!bus.out_valid && w < 40) begin
            @(posedge clk); #1; w++;
        end
        chk("bp_second", bus.data_out, CC);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;

        // Back-to-back stream, in_valid held, sink always ready
        for (int i = 0; i < 8; i++) begin
            vp[i] = (i % 2 == 0) ? PC : PB;
            vk[i] = (i % 2 == 0) ? KC : KB;
        end
        vp[5] = rnd128();
        vk[5] = rnd128();
        idx = 0; got = 0; cyc = 0;
        @(negedge clk);
        bus.out_ready = 1'b1;
        while (got < 8 && cyc < 200) begin
            if (cyc > 0) @(negedge clk);
            bus.in_valid = (idx < 8);
            if (idx < 8) begin
                bus.data_in = vp[idx];
                bus.key     = vk[idx];
            end
            #1;
            if (bus.out_valid) begin
                chk("b2b_ct", bus.data_out, ref_enc(vp[got], vk[got]));
                got++;
                if (idx < 8)
                    chk("b2b_accept", 128'(bus.in_ready), 128'd1);
            end
            if (bus.in_valid && bus.in_ready) idx++;
            cyc++;
        end
        chk("b2b_count", 128'(got), 128'd8);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;

        // Random blocks, inputs scrambled while in flight
        for (int n = 0; n < 6; n++) begin
            vp[0] = rnd128();
            vk[0] = rnd128();
            exp_a = ref_enc(vp[0], vk[0]);
            run_block(vp[0], vk[0], $urandom_range(0, 3), 1'b1, lat, ct);
            chk("rnd_latency", 128'(lat), 128'd10);
            chk("rnd_ct", ct, exp_a);
        end

        // Async reset in the middle of a block
        @(negedge clk);
        bus.data_in  = PC;
        bus.key      = KC;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("arst_busy", 128'(bus.busy), 128'd0);
        chk("arst_data_out", bus.data_out, 128'd0);
        chk("arst_in_ready", 128'(bus.in_ready), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_block(PB, KB, 1, 1'b1, lat, ct);
        chk("post_rst_latency", 128'(lat), 128'd10);
        chk("post_rst_ct", ct, CB);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
